flag_bank: RTL and testbench
============================

Name: flag_bank

Overview:
- Multi-channel, mode-selectable arming-flag register bank for the memory-game control path.
- Each channel raises a flag when its start request arrives while its qualifier is high. The flag then clears according to the selected mode: qualifier drop, explicit clear, or timeout.
- Also provides rise pulses, an any-flag summary, a lowest-index flag encoder and a saturating arm-event counter for the game FSM and score logic.

Parameters:
- CHANNELS, 4: number of independent flag channels, range 1..16.
- MODE, 0: clear policy for all channels. 0 = LEVEL (clear when qini low), 1 = STICKY (clear only via clr), 2 = TIMED (clear on qini low or timeout).
- HOLD_CYCLES, 16: TIMED-mode flag lifetime in clock cycles, at least 1. Ignored in other modes.
- CNT_W, 8: width of set_count.
- Derived localparam IDX_W = max(1, clog2(CHANNELS)).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  CHANNELS  per-channel arm request, level sampled each cycle.
- qini  input  CHANNELS  per-channel qualifier/enable.
- clr  input  CHANNELS  per-channel explicit clear.
- flag  output  CHANNELS  registered per-channel flag.
- flag_rise  output  CHANNELS  registered one-cycle pulse on a flag 0->1 transition.
- any_flag  output  1  OR of flag.
- first_idx  output  IDX_W  index of lowest-numbered set flag; 0 when none set.
- set_count  output  CNT_W  saturating count of cycles in which at least one flag rose.

Behaviour:
- Reset: reset=1 at a clock edge forces flag=0, flag_rise=0, all timers=0 and set_count=0. It overrides every other input and aborts a TIMED hold mid-count.
- Per-channel next-state priority, highest first: reset, clr[i], set, mode clear, hold.
- set = start[i] & qini[i]. The flag is 1 the cycle after the sampling edge (1-cycle latency).
- Mode clear:
  - LEVEL: qini[i]=0 -> flag 0.
  - STICKY: none; only clr[i] or reset clears the flag.
  - TIMED: qini[i]=0 -> flag 0, or timer[i]==HOLD_CYCLES-1 with no set -> flag 0.
- TIMED timer:
  - timer[i] loads 0 on every set, including a retrigger while already set, so the hold restarts.
  - Otherwise timer[i] increments while the flag is 1, and is 0 while the flag is 0.
  - Non-retriggered flag is high for exactly HOLD_CYCLES cycles. With HOLD_CYCLES=1 the flag is high for a single cycle.
- clr[i] with set in the same cycle: clr wins and the flag stays/becomes 0, with no rise pulse.
- A set while the flag is already 1: flag stays 1, no flag_rise, set_count unchanged (TIMED timer still reloads).
- flag_rise[i] is registered alongside flag: 1 exactly in the first cycle flag[i] reads 1 after being 0.
- any_flag and first_idx are combinational from the registered flag, so they have no extra latency relative to flag. first_idx gives priority to index 0.
- set_count:
  - Increments by 1 at each edge where at least one channel rises, regardless of how many channels rise.
  - Saturates at all ones and holds.
  - Cleared only by reset.
- No X propagation: unused upper first_idx codes are never produced.

Test Plan:
- LEVEL, CHANNELS=4: qini=4'b0011, pulse start=4'b0001 for 1 cycle, then drop qini[0].
  - Expect flag=0001 and flag_rise=0001 the next cycle, with flag_rise low afterwards.
  - Expect flag=0000 one cycle after qini[0] falls, and set_count=1.
- STICKY: set channels 2 and 1 in the same cycle, drop all qini.
  - Expect flag=0110 to hold, first_idx=1 and set_count incremented by 1 only.
  - Pulse clr[1]: expect flag=0100 and first_idx=2.
- TIMED, HOLD_CYCLES=5: single start pulse with qini held high -> flag high for exactly 5 cycles.
  - Retrigger start on the 3rd high cycle: flag stays high for 5 cycles after the retrigger, with no second flag_rise.
- Simultaneous clr[0] and start[0] with qini[0]=1: flag[0] stays 0, no flag_rise, set_count unchanged.
- Reset mid-hold (TIMED, cycle 2 of 5, set_count=3): assert reset for 1 cycle.
  - Expect flag=0, flag_rise=0, set_count=0 and any_flag=0 the following cycle.
  - A new start after reset gives a full 5-cycle hold.
- CNT_W=2: generate 5 separate rise events -> set_count reads 1, 2, 3, 3, 3 (saturation).

Source files
------------

// File: rtl/flag_bank.sv
// Per-channel arming flags with a shared clear policy (level, sticky or timed hold),
// plus rise pulses, an any/first-index summary and a saturating arm-event counter.
module flag_bank #(
   parameter int CHANNELS    = 4,
   parameter int MODE        = 0,
   parameter int HOLD_CYCLES = 16,
   parameter int CNT_W       = 8,
   localparam int IDX_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] start,
   input  logic [CHANNELS-1:0] qini,
   input  logic [CHANNELS-1:0] clr,
   output logic [CHANNELS-1:0] flag,
   output logic [CHANNELS-1:0] flag_rise,
   output logic                any_flag,
   output logic [IDX_W-1:0]    first_idx,
   output logic [CNT_W-1:0]    set_count
);

   localparam int MODE_LEVEL = 0;
   localparam int MODE_TIMED = 2;
   localparam int TMR_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(HOLD_CYCLES - 1);

   logic [CHANNELS-1:0] flag_q, flag_d;
   logic [CHANNELS-1:0] rise_q, rise_d;
   logic [TMR_W-1:0]    timer_q [CHANNELS];
   logic [TMR_W-1:0]    timer_d [CHANNELS];
   logic [CNT_W-1:0]    count_q, count_d;
   logic [CHANNELS-1:0] set_w;
   logic [CHANNELS-1:0] mode_clr_w;
   logic [IDX_W-1:0]    idx_w;

   always_ff @(posedge clk) begin
      if (reset) begin
         flag_q  <= '0;
         rise_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < CHANNELS; i++) timer_q[i] <= '0;
      end else begin
         flag_q  <= flag_d;
         rise_q  <= rise_d;
         count_q <= count_d;
         for (int i = 0; i < CHANNELS; i++) timer_q[i] <= timer_d[i];
      end
   end

   // Priority per channel: clr, set, mode clear, hold.
   always_comb begin
      flag_d     = flag_q;
      rise_d     = '0;
      set_w      = '0;
      mode_clr_w = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         timer_d[i] = '0;
         set_w[i]   = start[i] & qini[i];
         if (MODE == MODE_LEVEL) begin
            mode_clr_w[i] = ~qini[i];
         end else if (MODE == MODE_TIMED) begin
            mode_clr_w[i] = ~qini[i] | (timer_q[i] == TMR_LAST);
         end
         if (clr[i]) begin
            flag_d[i] = 1'b0;
         end else if (set_w[i]) begin
            flag_d[i] = 1'b1;
         end else if (mode_clr_w[i]) begin
            flag_d[i] = 1'b0;
         end
         rise_d[i] = flag_d[i] & ~flag_q[i];
         // A set (even a retrigger) restarts the hold from zero.
         if (MODE == MODE_TIMED && flag_d[i] && !set_w[i]) begin
            timer_d[i] = timer_q[i] + TMR_W'(1);
         end
      end
   end

   always_comb begin
      count_d = count_q;
      if (|rise_d && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Scan downward so the lowest set index is the last to write.
   always_comb begin
      idx_w = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (flag_q[i]) idx_w = IDX_W'(i);
      end
   end

   assign flag      = flag_q;
   assign flag_rise = rise_q;
   assign any_flag  = |flag_q;
   assign first_idx = idx_w;
   assign set_count = count_q;

endmodule

// File: tb/tb_flag_bank.sv
// Bench for flag_bank: four instances (LEVEL, STICKY, TIMED hold 5, TIMED hold 1 with a
// 2-bit counter) share one input stream; each is checked against a lifetime-based model.
module tb_flag_bank;

   localparam int NI = 4;
   localparam int EW = 19;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [3:0] start = '0, qini = '0, clr = '0;

   logic [3:0] flag0, rise0, flag1, rise1, flag2, rise2, flag3, rise3;
   logic       any0, any1, any2, any3;
   logic [1:0] idx0, idx1, idx2, idx3;
   logic [7:0] cnt0, cnt1, cnt2;
   logic [1:0] cnt3;

   int tests_run = 0;
   int tests_failed = 0;

   logic [NI*EW-1:0] exp_q[$];

   // Reference state: flag value and remaining lifetime per channel.
   bit m_flag [NI][4];
   int m_rem  [NI][4];
   int m_cnt  [NI];
   int mode_of [NI] = '{0, 1, 2, 2};
   int hold_of [NI] = '{16, 16, 5, 1};
   int cmax_of [NI] = '{255, 255, 255, 3};

   always #5 clk = ~clk;

   flag_bank #(.CHANNELS(4), .MODE(0), .HOLD_CYCLES(16), .CNT_W(8)) u_level (
      .clk(clk), .reset(reset), .start(start), .qini(qini), .clr(clr),
      .flag(flag0), .flag_rise(rise0), .any_flag(any0), .first_idx(idx0), .set_count(cnt0));
   flag_bank #(.CHANNELS(4), .MODE(1), .HOLD_CYCLES(16), .CNT_W(8)) u_sticky (
      .clk(clk), .reset(reset), .start(start), .qini(qini), .clr(clr),
      .flag(flag1), .flag_rise(rise1), .any_flag(any1), .first_idx(idx1), .set_count(cnt1));
   flag_bank #(.CHANNELS(4), .MODE(2), .HOLD_CYCLES(5), .CNT_W(8)) u_timed5 (
      .clk(clk), .reset(reset), .start(start), .qini(qini), .clr(clr),
      .flag(flag2), .flag_rise(rise2), .any_flag(any2), .first_idx(idx2), .set_count(cnt2));
   flag_bank #(.CHANNELS(4), .MODE(2), .HOLD_CYCLES(1), .CNT_W(2)) u_timed1 (
      .clk(clk), .reset(reset), .start(start), .qini(qini), .clr(clr),
      .flag(flag3), .flag_rise(rise3), .any_flag(any3), .first_idx(idx3), .set_count(cnt3));

   function automatic logic [EW-1:0] model_step(input int k, input logic [3:0] st,
                                                input logic [3:0] q, input logic [3:0] c,
                                                input logic r);
      logic [3:0] nf, rs;
      logic [1:0] idx;
      bit old, found;
      nf = '0;
      rs = '0;
      for (int ch = 0; ch < 4; ch++) begin
         old = m_flag[k][ch];
         if (r) begin
            m_flag[k][ch] = 0;
            m_rem[k][ch]  = 0;
         end else if (c[ch]) begin
            m_flag[k][ch] = 0;
         end else if (st[ch] && q[ch]) begin
            m_flag[k][ch] = 1;
            m_rem[k][ch]  = hold_of[k];
         end else if (m_flag[k][ch]) begin
            if (mode_of[k] == 0 && !q[ch]) m_flag[k][ch] = 0;
            if (mode_of[k] == 2) begin
               m_rem[k][ch] = m_rem[k][ch] - 1;
               if (!q[ch] || m_rem[k][ch] == 0) m_flag[k][ch] = 0;
            end
         end
         nf[ch] = m_flag[k][ch];
         rs[ch] = m_flag[k][ch] && !old;
      end
      if (r) m_cnt[k] = 0;
      else if (|rs && m_cnt[k] < cmax_of[k]) m_cnt[k] = m_cnt[k] + 1;
      idx = '0;
      found = 0;
      for (int ch = 0; ch < 4; ch++) begin
         if (nf[ch] && !found) begin
            idx = 2'(ch);
            found = 1;
         end
      end
      return {nf, rs, |nf, idx, 8'(m_cnt[k])};
   endfunction

   task automatic step(input logic [3:0] st, input logic [3:0] q, input logic [3:0] c,
                       input logic r);
      logic [NI*EW-1:0] e;
      @(negedge clk);
      start = st;
      qini  = q;
      clr   = c;
      reset = r;
      for (int k = 0; k < NI; k++) e[k*EW +: EW] = model_step(k, st, q, c, r);
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n, input logic [3:0] q);
      for (int i = 0; i < n; i++) step(4'b0000, q, 4'b0000, 1'b0);
   endtask

   task automatic cmp(input int k, input string name, input logic [7:0] got,
                      input logic [7:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("FAIL inst%0d %s got %0h want %0h at %0t", k, name, got, want, $time);
      end
   endtask

   task automatic check_inst(input int k, input logic [EW-1:0] e, input logic [EW-1:0] a);
      cmp(k, "flag",      8'(a[18:15]), 8'(e[18:15]));
      cmp(k, "flag_rise", 8'(a[14:11]), 8'(e[14:11]));
      cmp(k, "any_flag",  8'(a[10]),    8'(e[10]));
      cmp(k, "first_idx", 8'(a[9:8]),   8'(e[9:8]));
      cmp(k, "set_count", a[7:0],       e[7:0]);
   endtask

   // Monitor: every edge the DUTs present a new registered state.
   initial begin
      logic [NI*EW-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_inst(0, e[0*EW +: EW], {flag0, rise0, any0, idx0, cnt0});
            check_inst(1, e[1*EW +: EW], {flag1, rise1, any1, idx1, cnt1});
            check_inst(2, e[2*EW +: EW], {flag2, rise2, any2, idx2, cnt2});
            check_inst(3, e[3*EW +: EW], {flag3, rise3, any3, idx3, 6'b0, cnt3});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] st, q, c;
      logic r;
      step(4'b0000, 4'b0000, 4'b0000, 1'b1);
      step(4'b0000, 4'b0000, 4'b0000, 1'b1);
      // Single pulse on channel 0, then drop its qualifier.
      step(4'b0000, 4'b0011, 4'b0000, 1'b0);
      step(4'b0001, 4'b0011, 4'b0000, 1'b0);
      idle(2, 4'b0011);
      idle(3, 4'b0010);
      // Two channels in the same cycle, then all qualifiers low, then clr[1].
      step(4'b0110, 4'b0110, 4'b0000, 1'b0);
      idle(3, 4'b0000);
      step(4'b0000, 4'b0000, 4'b0010, 1'b0);
      idle(2, 4'b0000);
      step(4'b0000, 4'b0000, 4'b1111, 1'b0);
      // Timed hold and a retrigger on the third high cycle.
      step(4'b0001, 4'b0001, 4'b0000, 1'b0);
      idle(7, 4'b0001);
      step(4'b0001, 4'b0001, 4'b0000, 1'b0);
      idle(2, 4'b0001);
      step(4'b0001, 4'b0001, 4'b0000, 1'b0);
      idle(7, 4'b0001);
      step(4'b0000, 4'b0000, 4'b1111, 1'b0);
      // clr and set together on channel 0.
      step(4'b0001, 4'b0001, 4'b0001, 1'b0);
      idle(2, 4'b0001);
      // Reset in the middle of a hold, then a fresh full hold.
      step(4'b0001, 4'b0001, 4'b0000, 1'b0);
      idle(1, 4'b0001);
      step(4'b0001, 4'b0001, 4'b0000, 1'b1);
      idle(1, 4'b0001);
      step(4'b0001, 4'b0001, 4'b0000, 1'b0);
      idle(7, 4'b0001);
      // Five separate rise events to saturate the narrow counter.
      for (int n = 0; n < 5; n++) begin
         step(4'b0000, 4'b1111, 4'b1111, 1'b0);
         step(4'b0100, 4'b1111, 4'b0000, 1'b0);
         idle(1, 4'b1111);
      end
      // Randomised traffic.
      for (int n = 0; n < 600; n++) begin
         st = 4'($urandom) & 4'($urandom);
         q  = 4'($urandom) | 4'($urandom);
         c  = 4'($urandom) & 4'($urandom) & 4'($urandom);
         r  = ($urandom_range(0, 59) == 0);
         step(st, q, c, r);
      end
      idle(3, 4'b0000);
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL drain pending %0d want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
